// File: rtl/adc_sample_capture.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_capture
//  Description : ADC capture engine. A trigger-started capture writes
//                qualified ADC samples into an on-chip buffer. An Avalon-MM
//                slave exposes control/status, buffer readout, read pointer
//                and capture timestamp.
//                Optional macro ADC_CAPTURE_TSTAMP_EN adds a free-running
//                32-bit cycle counter that is latched when a capture starts.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_capture #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       sample_num,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              trigger,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              capture_done
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [31:0]       DEPTH_W32 = 32'd1 << ADDR_W;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = DEPTH_W32[CNT_W-1:0];
  localparam logic [CNT_W-1:0]  LEN_RESET = CNT_W'(15);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_RD_PTR = 2'd2;
  localparam logic [1:0] REG_TSTAMP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  len_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [CNT_W-1:0]  count_inc;
  logic [CNT_W-1:0]  sample_len;
  logic [31:0]       sample_num_ext;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              sample_wr;
  logic              ctrl_wr;
  logic              ptr_wr;
  logic              data_rd;
  logic              do_arm;
  logic              do_abort;
  logic [31:0]       status_word;
  logic [31:0]       rd_mux;
  logic [31:0]       tstamp;
  logic              unused_wdata;

  // Bus decode
  assign ctrl_wr  = chipselect & ~write_n & (address == REG_CTRL);
  assign ptr_wr   = chipselect & ~write_n & (address == REG_RD_PTR);
  assign data_rd  = chipselect & ~read_n  & (address == REG_DATA);
  assign do_abort = ctrl_wr & writedata[1];
  assign do_arm   = ctrl_wr & writedata[0];

  assign unused_wdata = ^writedata[31:ADDR_W];

  // Requested length clipped to the buffer depth
  assign sample_num_ext = {16'd0, sample_num};
  assign sample_len     = (sample_num_ext > DEPTH_W32) ? DEPTH_CNT
                                                       : sample_num_ext[CNT_W-1:0];
  assign count_inc      = count + CNT_W'(1);

  assign capture_done = (state == S_DONE);

  // State, count and latched length registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      count <= '0;
      len   <= LEN_RESET;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      len   <= len_nxt;
    end
  end

  // Next-state logic; abort overrides everything and freezes count/buffer
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    len_nxt   = len;
    sample_wr = 1'b0;
    if (do_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (do_arm) begin
            len_nxt   = sample_len;
            count_nxt = '0;
            state_nxt = (sample_len == '0) ? S_DONE : S_ARMED;
          end
        end
        S_ARMED: begin
          if (trigger) begin
            state_nxt = S_CAPTURE;
            // A sample coincident with the trigger is sample 0
            if (adc_valid) begin
              sample_wr = 1'b1;
              count_nxt = count_inc;
              if (count_inc == len) state_nxt = S_DONE;
            end
          end
        end
        S_CAPTURE: begin
          if (adc_valid) begin
            sample_wr = 1'b1;
            count_nxt = count_inc;
            if (count_inc == len) state_nxt = S_DONE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Sample buffer write port; contents survive reset and abort
  always_ff @(posedge clk) begin
    if (sample_wr) mem[count[ADDR_W-1:0]] <= adc_data;
  end

`ifdef ADC_CAPTURE_TSTAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] tstamp_q;
  logic        start_capture;

  assign start_capture = (state == S_ARMED) & trigger & ~do_abort;

  // Free-running cycle counter, captured when a capture begins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
      tstamp_q  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (start_capture) tstamp_q <= cycle_cnt;
    end
  end

  assign tstamp = tstamp_q;
`else
  assign tstamp = '0;
`endif

  assign status_word = {16'(count), 13'd0,
                        (state == S_ARMED),
                        (state == S_DONE),
                        (state == S_ARMED) | (state == S_CAPTURE)};

  // Read data mux; deselected or undefined accesses yield zero
  always_comb begin
    rd_mux = '0;
    if (chipselect) begin
      case (address)
        REG_CTRL:   rd_mux = status_word;
        REG_DATA:   rd_mux = 32'(mem[rd_ptr]);
        REG_RD_PTR: rd_mux = 32'(rd_ptr);
        REG_TSTAMP: rd_mux = tstamp;
        default:    rd_mux = '0;
      endcase
    end
  end

  // Registered read data and read pointer; readdata holds between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      rd_ptr   <= '0;
    end else begin
      if (ptr_wr) begin
        rd_ptr <= writedata[ADDR_W-1:0];
      end else if (data_rd) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (!read_n) readdata <= rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_sample_capture
//  Description : Self-checking bench for adc_sample_capture: table-driven
//                capture vectors, directed corner sequences and randomized
//                captures against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sample_capture;

  localparam int DW    = 14;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [15:0]   sample_num;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic          trigger;
  logic [1:0]    address;
  logic          chipselect;
  logic          read_n;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          capture_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]   rd_buf [DEPTH];
  logic [DW-1:0] mq [$];

  typedef struct {
    logic [15:0] sn;
    int          exp_len;
    logic [31:0] exp_status;
  } cap_vec_t;

  cap_vec_t vecs [5];

  adc_sample_capture #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_num   (sample_num),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .trigger      (trigger),
    .address      (address),
    .chipselect   (chipselect),
    .read_n       (read_n),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .capture_done (capture_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    tick();
    v          = readdata;
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  // Back-to-back DATA reads, one word per cycle
  task automatic burst_read(input int n);
    address    = 2'd1;
    chipselect = 1'b1;
    read_n     = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      rd_buf[i] = readdata;
    end
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  // Trigger with continuous valid samples base, base+1, ... until done
  task automatic run_continuous(input int budget, input int base, output int n);
    n = 0;
    while (!capture_done && n < budget) begin
      trigger   = 1'b1;
      adc_valid = 1'b1;
      adc_data  = DW'(base + n);
      tick();
      n++;
    end
    trigger   = 1'b0;
    adc_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int          n;
    int          mlen;
    int          sn;
    int          pre;

    vecs[0] = '{sn: 16'd8,    exp_len: 8,    exp_status: 32'h0008_0002};
    vecs[1] = '{sn: 16'd1,    exp_len: 1,    exp_status: 32'h0001_0002};
    vecs[2] = '{sn: 16'd0,    exp_len: 0,    exp_status: 32'h0000_0002};
    vecs[3] = '{sn: 16'd3,    exp_len: 3,    exp_status: 32'h0003_0002};
    vecs[4] = '{sn: 16'd2000, exp_len: 1024, exp_status: 32'h0400_0002};

    reset_n    = 1'b0;
    sample_num = '0;
    adc_data   = '0;
    adc_valid  = 1'b0;
    trigger    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    writedata  = '0;

    // Reset state
    repeat (2) tick();
    check("rst_done", 32'(capture_done), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();
    check("rel_no_arm_done", 32'(capture_done), 32'd0);
    bus_read(2'd0, v); check("rst_status", v, 32'd0);
    bus_read(2'd2, v); check("rst_rd_ptr", v, 32'd0);
    bus_read(2'd3, v); check("rst_tstamp", v, 32'd0);

    // RD_PTR load, readdata hold, deselected read
    bus_write(2'd2, 32'd5);
    bus_read(2'd2, v); check("rd_ptr_load", v, 32'd5);
    repeat (2) tick();
    check("readdata_hold", readdata, 32'd5);
    address = 2'd2; chipselect = 1'b0; read_n = 1'b0;
    tick();
    read_n = 1'b1;
    check("cs_low_read", readdata, 32'd0);

    // Table-driven captures
    for (int t = 0; t < 5; t++) begin
      sample_num = vecs[t].sn;
      bus_write(2'd0, 32'd1);
      check($sformatf("vec%0d_done_after_arm", t), 32'(capture_done),
            (vecs[t].exp_len == 0) ? 32'd1 : 32'd0);
      run_continuous(1100, 0, n);
      check($sformatf("vec%0d_valid_cycles", t), 32'(n), 32'(vecs[t].exp_len));
      check($sformatf("vec%0d_done", t), 32'(capture_done), 32'd1);
      bus_read(2'd0, v);
      check($sformatf("vec%0d_status", t), v, vecs[t].exp_status);
      if (vecs[t].exp_len > 0) begin
        n = (vecs[t].exp_len < 8) ? vecs[t].exp_len : 8;
        bus_write(2'd2, 32'd0);
        burst_read(n);
        for (int i = 0; i < n; i++)
          check($sformatf("vec%0d_data%0d", t, i), rd_buf[i], 32'(i));
      end
    end

    // Read pointer wrap after a full-depth capture (buffer[k] = k)
    bus_write(2'd2, 32'd1023);
    bus_read(2'd2, v); check("wrap_ptr", v, 32'd1023);
    burst_read(2);
    check("wrap_last", rd_buf[0], 32'd1023);
    check("wrap_first", rd_buf[1], 32'd0);
    bus_read(2'd2, v); check("wrap_ptr_after", v, 32'd1);

    // Zero length: done at once and trigger ignored
    sample_num = 16'd0;
    bus_write(2'd0, 32'd1);
    check("zero_done", 32'(capture_done), 32'd1);
    trigger = 1'b1; adc_valid = 1'b1; adc_data = 14'h3ff;
    repeat (3) tick();
    trigger = 1'b0; adc_valid = 1'b0;
    bus_read(2'd0, v); check("zero_status", v, 32'h0000_0002);

    // Arm while armed is ignored
    sample_num = 16'd4;
    bus_write(2'd0, 32'd1);
    bus_read(2'd0, v); check("armed_status", v, 32'h0000_0005);
    sample_num = 16'd9;
    bus_write(2'd0, 32'd1);
    run_continuous(50, 0, n);
    check("rearm_ignored_len", 32'(n), 32'd4);

    // Abort after five samples, then arm+abort together
    sample_num = 16'd16;
    bus_write(2'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      trigger = 1'b1; adc_valid = 1'b1; adc_data = DW'(32'h200 + i);
      tick();
    end
    trigger = 1'b0; adc_valid = 1'b0;
    bus_read(2'd0, v); check("capture_status", v, 32'h0005_0001);
    bus_write(2'd0, 32'd2);
    check("abort_done", 32'(capture_done), 32'd0);
    bus_read(2'd0, v); check("abort_status", v, 32'h0005_0000);
    bus_write(2'd0, 32'd3);
    bus_read(2'd0, v); check("arm_abort_status", v, 32'h0005_0000);
    bus_write(2'd2, 32'd0);
    bus_read(2'd1, v); check("abort_buf0", v, 32'h200);

    // Randomized captures against the queue model
    for (int it = 0; it < 12; it++) begin
      mq.delete();
      sn = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
      sample_num = 16'(sn);
      bus_write(2'd0, 32'd1);
      mlen = (sn > DEPTH) ? DEPTH : sn;
      check($sformatf("rand%0d_arm_done", it), 32'(capture_done),
            (mlen == 0) ? 32'd1 : 32'd0);
      if (mlen != 0) begin
        pre = int'($urandom_range(0, 4));
        for (int p = 0; p < pre; p++) begin
          trigger = 1'b0; adc_valid = 1'($urandom); adc_data = DW'($urandom);
          tick();
          check($sformatf("rand%0d_wait_done", it), 32'(capture_done), 32'd0);
        end
        for (int c = 0; c < 600 && mq.size() < mlen; c++) begin
          trigger   = (c == 0) ? 1'b1 : 1'($urandom);
          adc_valid = 1'($urandom);
          adc_data  = DW'($urandom);
          tick();
          if (adc_valid && mq.size() < mlen) mq.push_back(adc_data);
          check($sformatf("rand%0d_done", it), 32'(capture_done),
                (mq.size() == mlen) ? 32'd1 : 32'd0);
        end
        trigger = 1'b0; adc_valid = 1'b0;
        check($sformatf("rand%0d_model_len", it), 32'(mq.size()), 32'(mlen));
      end
      bus_read(2'd0, v);
      check($sformatf("rand%0d_status", it), v, (32'(mlen) << 16) | 32'd2);
      if (mlen != 0) begin
        bus_write(2'd2, 32'd0);
        burst_read(mlen);
        for (int i = 0; i < mlen && i < mq.size(); i++)
          check($sformatf("rand%0d_data%0d", it, i), rd_buf[i], 32'(mq[i]));
      end
    end

    // Reset pulsed mid-capture
    sample_num = 16'd16;
    bus_write(2'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      trigger = 1'b1; adc_valid = 1'b1; adc_data = DW'(32'h100 + i);
      tick();
    end
    trigger = 1'b0; adc_valid = 1'b0;
    bus_read(2'd0, v); check("midcap_status", v, 32'h0003_0001);
    reset_n = 1'b0;
    #1;
    check("midrst_readdata", readdata, 32'd0);
    check("midrst_done", 32'(capture_done), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) tick();
    bus_read(2'd0, v); check("midrst_status", v, 32'd0);
    bus_read(2'd1, v); check("midrst_buf_kept", v, 32'h100);

    // Timestamp: trigger sampled on the 100th edge after reset release
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sample_num = 16'd4;
    bus_write(2'd0, 32'd1);
    repeat (98) tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    bus_read(2'd3, v);
`ifdef ADC_CAPTURE_TSTAMP_EN
    check("tstamp", (v >= 32'd99 && v <= 32'd101) ? 32'd100 : v, 32'd100);
`else
    check("tstamp", v, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_sample_capture.md
ADC_SAMPLE_CAPTURE -- requirements
Module: adc_sample_capture

Interface
REQ-001 Parameter DATA_W, default 14, ADC sample width in bits.
REQ-002 Parameter ADDR_W, default 10, buffer address width; depth = 2^ADDR_W samples.
REQ-003 clk  in  1  single clock; all logic synchronous to its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 sample_num  in  16  requested samples per capture, driven by the sampleNum PIO out_port.
REQ-006 adc_data  in  DATA_W  ADC sample.
REQ-007 adc_valid  in  1  adc_data qualifier, one sample per asserted cycle.
REQ-008 trigger  in  1  capture start, level-sampled each cycle.
REQ-009 address  in  2  Avalon-MM slave word address.
REQ-010 chipselect, read_n, write_n  in  1 each  Avalon-MM controls, read_n/write_n active-low.
REQ-011 writedata  in  32  Avalon-MM write data.
REQ-012 readdata  out  32  Avalon-MM read data, read latency 1.
REQ-013 capture_done  out  1  level, high in DONE state.

Function
REQ-014 FSM states SHALL be IDLE, ARMED, CAPTURE, DONE.
REQ-015 Register map: 0 CTRL/STATUS, 1 DATA, 2 RD_PTR, 3 TSTAMP.
REQ-016 CTRL write bit0=arm, bit1=abort; abort wins if both set.
REQ-017 Arm from IDLE or DONE -> ARMED: latch sample_num, clear count, clear write pointer; arm in ARMED/CAPTURE ignored.
REQ-018 Latched length = min(sample_num, 2^ADDR_W); latched length 0 -> arm goes directly to DONE with count 0.
REQ-019 ARMED and trigger=1 -> CAPTURE; if adc_valid also high that cycle, that sample is sample 0.
REQ-020 Trigger in IDLE, CAPTURE, DONE ignored.
REQ-021 In CAPTURE each adc_valid cycle writes adc_data to buffer[count] and increments count.
REQ-022 The cycle count reaches latched length, state -> DONE; no further writes.
REQ-023 Abort from any state -> IDLE next cycle; count and buffer contents held.
REQ-024 STATUS read: bit0 busy (ARMED or CAPTURE), bit1 done, bit2 armed, bits31:16 count, other bits 0.
REQ-025 DATA read returns buffer[rd_ptr] zero-extended, then rd_ptr increments, wrapping at 2^ADDR_W.
REQ-026 RD_PTR write loads rd_ptr from writedata[ADDR_W-1:0]; RD_PTR read returns rd_ptr.
REQ-027 Back-to-back DATA reads SHALL return consecutive words with no bubble.
REQ-028 Reads of undefined registers or with chipselect low return 0; DATA read during CAPTURE allowed, content undefined beyond count.
REQ-029 readdata updates only in the cycle after a read; holds value otherwise.

Reset
REQ-030 On reset_n low: state IDLE, capture_done 0, readdata 0, count 0, rd_ptr 0, latched length 15, timestamp registers 0.
REQ-031 Reset mid-CAPTURE aborts immediately; buffer contents not cleared.
REQ-032 Release of reset_n SHALL not itself cause an arm or trigger.

Configuration
REQ-033 Macro ADC_CAPTURE_TSTAMP_EN defined: free-running 32-bit cycle counter, wrapping, latched on ARMED->CAPTURE transition; TSTAMP read returns latched value.
REQ-034 Macro undefined: no counter or latch logic; TSTAMP read returns 0.

Verification
REQ-035 sample_num=8, arm, trigger, adc_valid continuous with data 0..9 -> DONE after 8 valid cycles, count=8, DATA reads from ptr 0 return 0..7.
REQ-036 sample_num=0, arm -> capture_done=1 next cycle, STATUS bits31:16=0, trigger ignored.
REQ-037 sample_num=2000 with ADDR_W=10 -> capture stops at count 1024; DATA read at rd_ptr 1023 then next read returns buffer[0].
REQ-038 sample_num=16, abort after 5 samples -> IDLE, count=5, capture_done=0; arm+abort same write -> remains IDLE.
REQ-039 reset_n pulsed low mid-CAPTURE -> state IDLE, readdata 0, STATUS read returns 0.
REQ-040 ADC_CAPTURE_TSTAMP_EN defined, trigger 100 cycles after reset release -> TSTAMP reads 100 (+/-1 per documented edge); undefined -> reads 0.
